// File: rtl/mmio_master.sv
// MMIO master: one outstanding command -> single bus transfer -> response.
// Optional bus timeout compiled in with MMIO_MASTER_TIMEOUT_EN.
module mmio_master #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        valid,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic [31:0] rdata,
  input  logic        ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   cmd_ready_q;
  logic   tmo;

  assign valid     = (state == BUS);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign cmd_ready = cmd_ready_q;

`ifdef MMIO_MASTER_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  logic             err_q;

  assign tmo     = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err = err_q;

  // Wait counter: restarts on every BUS entry, counts cycles without ready.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (state != BUS)
      cnt <= '0;
    else if (!ready)
      cnt <= cnt + 1'b1;
  end

  // Error flag: set only when the bus abandons a transfer.
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (state == BUS)
      err_q <= !ready && tmo;
  end
`else
  assign tmo     = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // Control FSM with bus request and response data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
      wstrb       <= '0;
      rsp_rdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_ready_q && cmd_valid) begin
            state       <= BUS;
            cmd_ready_q <= 1'b0;
            addr        <= cmd_addr;
            wdata       <= cmd_wdata;
            if (!cmd_write)
              wstrb <= 4'b0000;
            else if (cmd_wstrb == 4'b0000)
              wstrb <= 4'b1111;
            else
              wstrb <= cmd_wstrb;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        BUS: begin
          if (ready) begin
            state     <= RESP;
            rsp_rdata <= rdata;
          end else if (tmo) begin
            state     <= RESP;
            rsp_rdata <= 32'h0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          cmd_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_master.sv
// Bench for mmio_master: transaction model compared every cycle,
// directed latency/write/stall/timeout/reset cases plus random traffic.
module tb_mmio_master;

  localparam int TO = 16;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mmio_master #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .valid(valid),
    .addr(addr),
    .wdata(wdata),
    .wstrb(wstrb),
    .rdata(rdata),
    .ready(ready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: an accepted command becomes one
  // pending bus transfer, which becomes one pending response.
  bit          m_can_accept;
  bit          m_on_bus;
  bit          m_rsp_pend;
  int          m_waited;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_strb;
  logic [31:0] m_rdata;
  bit          m_err;

  initial begin
    m_can_accept = 0;
    m_on_bus     = 0;
    m_rsp_pend   = 0;
    m_waited     = 0;
    m_addr       = 0;
    m_wdata      = 0;
    m_strb       = 0;
    m_rdata      = 0;
    m_err        = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_can_accept = 0;
      m_on_bus     = 0;
      m_rsp_pend   = 0;
      m_addr       = 0;
      m_wdata      = 0;
      m_strb       = 0;
      m_rdata      = 0;
      m_err        = 0;
    end else if (m_rsp_pend) begin
      if (rsp_ready) begin
        m_rsp_pend   = 0;
        m_can_accept = 1;
      end
    end else if (m_on_bus) begin
      if (ready) begin
        m_on_bus   = 0;
        m_rsp_pend = 1;
        m_rdata    = rdata;
        m_err      = 0;
      end else begin
        m_waited++;
`ifdef MMIO_MASTER_TIMEOUT_EN
        if (m_waited >= TO) begin
          m_on_bus   = 0;
          m_rsp_pend = 1;
          m_rdata    = 0;
          m_err      = 1;
        end
`endif
      end
    end else if (m_can_accept && cmd_valid) begin
      m_can_accept = 0;
      m_on_bus     = 1;
      m_waited     = 0;
      m_addr       = cmd_addr;
      m_wdata      = cmd_wdata;
      m_strb       = !cmd_write ? 4'h0 :
                     (cmd_wstrb == 4'h0) ? 4'hF : cmd_wstrb;
    end else begin
      m_can_accept = 1;
    end
  end

  // Compare process: outputs against the model on every falling edge.
  always @(negedge clk) begin
    check("valid", valid, 32'(m_on_bus));
    check("rsp_valid", rsp_valid, 32'(m_rsp_pend));
    check("busy", busy, 32'(m_on_bus || m_rsp_pend));
    check("cmd_ready", cmd_ready, 32'(m_can_accept));
    if (m_on_bus) begin
      check("addr", addr, m_addr);
      check("wdata", wdata, m_wdata);
      check("wstrb", wstrb, 32'(m_strb));
    end
    if (m_rsp_pend) begin
      check("rsp_rdata", rsp_rdata, m_rdata);
      check("rsp_err", rsp_err, 32'(m_err));
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  int vcnt;
  bit saw_rsp;

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    cmd_wstrb = 4'h0;
    rsp_ready = 1'b0;
    rdata     = 32'h0;
    ready     = 1'b0;

    // Reset values.
    step();
    check("rst_valid", valid, 32'h0);
    check("rst_cmd_ready", cmd_ready, 32'h0);
    check("rst_busy", busy, 32'h0);
    check("rst_addr", addr, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    rst = 1'b0;
    step();
    check("post_rst_cmd_ready", cmd_ready, 32'h1);

    // Read with one-cycle responder: accepted at edge N.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h1000_0000;
    step();
    cmd_valid = 1'b0;
    check("rd_valid_n1", valid, 32'h1);
    check("rd_addr", addr, 32'h1000_0000);
    check("rd_wstrb", wstrb, 32'h0);
    check("rd_cmd_ready", cmd_ready, 32'h0);
    step();
    ready = 1'b1;
    rdata = 32'h0000_00A5;
    check("rd_rsp_not_yet", rsp_valid, 32'h0);
    step();
    ready = 1'b0;
    check("rd_rsp_valid_n3", rsp_valid, 32'h1);
    check("rd_rdata", rsp_rdata, 32'h0000_00A5);
    check("rd_err", rsp_err, 32'h0);
    check("rd_valid_low", valid, 32'h0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rd_done", rsp_valid, 32'h0);

    // Partial-strobe write, then strobe-0 write with stalled response
    // and a responder that keeps ready high afterwards.
    step();
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_wdata = 32'hDEAD_BEEF;
    cmd_wstrb = 4'b0011;
    step();
    cmd_valid = 1'b0;
    check("wr_wstrb", wstrb, 32'h3);
    step();
    check("wr_wdata_hold", wdata, 32'hDEAD_BEEF);
    ready = 1'b1;
    rdata = 32'h1234_5678;
    step();
    ready = 1'b0;
    check("wr_rsp", rsp_valid, 32'h1);
    check("wr_rsp_data", rsp_rdata, 32'h1234_5678);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_wstrb = 4'b0000;
    step();
    cmd_valid = 1'b0;
    check("wr0_wstrb", wstrb, 32'hF);
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_rsp_valid", rsp_valid, 32'h1);
      check("stall_cmd_ready", cmd_ready, 32'h0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    step();
    ready = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd_write = $urandom_range(0, 1) == 1;
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_wstrb = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      ready     = ($urandom_range(0, 2) == 0);
      rdata     = $urandom;
      rsp_ready = $urandom_range(0, 1) == 1;
      step();
    end

    // Responder never answers.
    rst       = 1'b0;
    ready     = 1'b0;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    do_reset();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    step();
    cmd_valid = 1'b0;
    vcnt    = 0;
    saw_rsp = 0;
    for (int i = 0; i < 120; i++) begin
      if (valid) vcnt++;
      if (rsp_valid) saw_rsp = 1;
      step();
    end
`ifdef MMIO_MASTER_TIMEOUT_EN
    check("tmo_valid_cycles", vcnt, TO);
    check("tmo_rsp", rsp_valid, 32'h1);
    check("tmo_err", rsp_err, 32'h1);
    check("tmo_rdata", rsp_rdata, 32'h0);
`else
    check("hang_valid_cycles", vcnt, 120);
    check("hang_no_rsp", 32'(saw_rsp), 32'h0);
`endif

    // Reset in the middle of a bus transfer.
    do_reset();
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("mid_valid", valid, 32'h1);
    rst = 1'b1;
    step();
    check("mid_rst_valid", valid, 32'h0);
    check("mid_rst_rsp", rsp_valid, 32'h0);
    rst = 1'b0;
    step();
    check("mid_rst_cmd_ready", cmd_ready, 32'h1);
    check("mid_rst_no_rsp", rsp_valid, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
